multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core variant: sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction, for R-type, lw, sw, beq and addi. It sits beside the datapath's IR, PC, ALUOut and Data registers and drives their enables and muxes. It stalls on a ready/request memory handshake, traps on unsupported opcodes and counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 45 ++++
 rtl/immsrc_decoder.sv | 18 +
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I cores: opcodes, multicycle FSM
// states and the datapath mux/ALU encodings driven by the controllers.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/immsrc_decoder.sv
// Opcode to immediate-format select; shared by the single- and multicycle cores.
module immsrc_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready and counts retirements.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal_instr,
  output logic [3:0]       fsm_state
);

  state_t state, next;
  logic   pc_update;
  logic   branch;

  immsrc_decoder u_immsrc (
    .opcode  (Opcode),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:    if (mem_ready) next = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECUTER;
          OP_ADDI:      next = EXECUTEI;
          OP_BEQ:       next = BEQ;
          default:      next = TRAP;
        endcase
      end
      MEMADR:   next = (Opcode == OP_LW) ? MEMREAD :
                       (Opcode == OP_SW) ? MEMWRITE : TRAP;
      MEMREAD:  if (mem_ready) next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: if (mem_ready) next = FETCH;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      ALUWB:    next = FETCH;
      BEQ:      next = FETCH;
      TRAP:     next = TRAP;
      default:  next = TRAP;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_REGB;
    ALUOp         = ALUOP_ADD;
    ResultSrc     = RES_ALUOUT;
    instr_retired = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc     = RES_DATA;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      MEMWRITE: begin
        mem_req       = 1'b1;
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = mem_ready;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_REGA;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      BEQ: begin
        ALUSrcA       = SRCA_REGA;
        ALUOp         = ALUOP_SUB;
        branch        = 1'b1;
        instr_retired = 1'b1;
      end
      default: ;
    endcase
    // During reset the stored state may be anything: kill every enable so an
    // in-flight access never completes, and present the FETCH mux settings.
    if (reset) begin
      mem_req       = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      instr_retired = 1'b0;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_FOUR;
      ALUOp         = ALUOP_ADD;
      ResultSrc     = RES_ALURESULT;
    end
  end

  assign PCWrite       = pc_update | (branch & Zero);
  assign illegal_instr = (state == TRAP);
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (reset)              retired_cnt <= '0;
    else if (instr_retired) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state, control word,
// ImmSrc and retire-count checks over each instruction class, stalls and resets.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       instr_retired, illegal_instr;
  logic [3:0] retired_cnt;
  logic [3:0] fsm_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = '0;

  // Control word: {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
  //                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, instr_retired, illegal_instr}
  localparam logic [15:0] F_RDY   = {6'b101100, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] F_STL   = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] DEC_C   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] MADR_C  = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] MRD_C   = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] MWB_C   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] MWR_STL = {6'b110010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] MWR_RDY = {6'b110010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] EXR_C   = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] EXI_C   = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] AWB_C   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] BEQ_T   = {6'b000100, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  localparam logic [15:0] BEQ_N   = {6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  localparam logic [15:0] TRP_C   = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [15:0] RST_C   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] RST_TRP = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01};

  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_BAD  = 7'h7F;

  logic [15:0] obs_ctl;
  assign obs_ctl = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, ResultSrc, instr_retired, illegal_instr};

  multicycle_controller #(.CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .Opcode        (Opcode),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .ImmSrc        (ImmSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .ResultSrc     (ResultSrc),
    .instr_retired (instr_retired),
    .retired_cnt   (retired_cnt),
    .illegal_instr (illegal_instr),
    .fsm_state     (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance, update the count model.
  task automatic step(input string tag, input logic rst, input logic rdy, input logic zro,
                      input state_t st, input logic [15:0] ctl, input logic [1:0] imm);
    reset     = rst;
    mem_ready = rdy;
    Zero      = zro;
    #1;
    chk({tag, "_state"}, 32'(fsm_state), 32'(st));
    chk({tag, "_ctl"},   32'(obs_ctl),   32'(ctl));
    chk({tag, "_imm"},   32'(ImmSrc),    32'(imm));
    chk({tag, "_cnt"},   32'(retired_cnt), 32'(exp_cnt));
    @(posedge clk);
    #1;
    if (rst)         exp_cnt = '0;
    else if (ctl[1]) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic do_r(input string tag);
    Opcode = OPC_R;
    step({tag, "_f"},  1'b0, 1'b1, 1'b0, FETCH,    F_RDY, 2'b00);
    step({tag, "_d"},  1'b0, 1'b1, 1'b0, DECODE,   DEC_C, 2'b00);
    step({tag, "_x"},  1'b0, 1'b0, 1'b0, EXECUTER, EXR_C, 2'b00);
    step({tag, "_wb"}, 1'b0, 1'b1, 1'b0, ALUWB,    AWB_C, 2'b00);
  endtask

  task automatic do_addi(input string tag);
    Opcode = OPC_ADDI;
    step({tag, "_f"},  1'b0, 1'b1, 1'b0, FETCH,    F_RDY, 2'b00);
    step({tag, "_d"},  1'b0, 1'b1, 1'b0, DECODE,   DEC_C, 2'b00);
    step({tag, "_x"},  1'b0, 1'b1, 1'b0, EXECUTEI, EXI_C, 2'b00);
    step({tag, "_wb"}, 1'b0, 1'b1, 1'b0, ALUWB,    AWB_C, 2'b00);
  endtask

  initial begin
    reset = 1'b1; Opcode = OPC_ADDI; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b1, 1'b0, FETCH, RST_C, 2'b00);

    // addi 0x00500093: 4 cycles, single writeback cycle, count -> 1
    do_addi("addi");

    // lw with two MEMREAD stalls: 7 cycles total
    Opcode = OPC_LW;
    step("lw_f",   1'b0, 1'b1, 1'b0, FETCH,   F_RDY,  2'b00);
    step("lw_d",   1'b0, 1'b1, 1'b0, DECODE,  DEC_C,  2'b00);
    step("lw_adr", 1'b0, 1'b1, 1'b0, MEMADR,  MADR_C, 2'b00);
    step("lw_rd0", 1'b0, 1'b0, 1'b0, MEMREAD, MRD_C,  2'b00);
    step("lw_rd1", 1'b0, 1'b0, 1'b0, MEMREAD, MRD_C,  2'b00);
    step("lw_rd2", 1'b0, 1'b1, 1'b0, MEMREAD, MRD_C,  2'b00);
    step("lw_wb",  1'b0, 1'b1, 1'b0, MEMWB,   MWB_C,  2'b00);

    // beq taken (with one fetch stall first), then beq not taken
    Opcode = OPC_BEQ;
    step("beqt_fs", 1'b0, 1'b0, 1'b1, FETCH,  F_STL, 2'b10);
    step("beqt_f",  1'b0, 1'b1, 1'b1, FETCH,  F_RDY, 2'b10);
    step("beqt_d",  1'b0, 1'b1, 1'b1, DECODE, DEC_C, 2'b10);
    step("beqt_b",  1'b0, 1'b1, 1'b1, BEQ,    BEQ_T, 2'b10);
    step("beqn_f",  1'b0, 1'b1, 1'b0, FETCH,  F_RDY, 2'b10);
    step("beqn_d",  1'b0, 1'b1, 1'b1, DECODE, DEC_C, 2'b10);
    step("beqn_b",  1'b0, 1'b1, 1'b0, BEQ,    BEQ_N, 2'b10);

    do_r("r");

    // sw with one MEMWRITE stall: MemWrite for 2 cycles, retire only with mem_ready
    Opcode = OPC_SW;
    step("sw_f",   1'b0, 1'b1, 1'b0, FETCH,    F_RDY,   2'b01);
    step("sw_d",   1'b0, 1'b1, 1'b0, DECODE,   DEC_C,   2'b01);
    step("sw_adr", 1'b0, 1'b1, 1'b0, MEMADR,   MADR_C,  2'b01);
    step("sw_w0",  1'b0, 1'b0, 1'b0, MEMWRITE, MWR_STL, 2'b01);
    step("sw_w1",  1'b0, 1'b1, 1'b0, MEMWRITE, MWR_RDY, 2'b01);

    // Six retired so far; eleven more make 17, which wraps the 4-bit counter to 1
    for (int i = 0; i < 11; i++) do_r($sformatf("rwrap%0d", i));
    #1;
    chk("wrap_cnt", 32'(retired_cnt), 32'd1);

    // Reset during a MEMWRITE stall: no write strobe, no retirement, count cleared
    Opcode = OPC_SW;
    step("swr_f",   1'b0, 1'b1, 1'b0, FETCH,    F_RDY,   2'b01);
    step("swr_d",   1'b0, 1'b1, 1'b0, DECODE,   DEC_C,   2'b01);
    step("swr_adr", 1'b0, 1'b1, 1'b0, MEMADR,   MADR_C,  2'b01);
    step("swr_w0",  1'b0, 1'b0, 1'b0, MEMWRITE, MWR_STL, 2'b01);
    step("swr_rst", 1'b1, 1'b1, 1'b0, MEMWRITE, RST_C,   2'b01);
    step("swr_f2",  1'b0, 1'b0, 1'b0, FETCH,    F_STL,   2'b01);

    do_addi("addi2");

    // Unsupported opcode traps and holds regardless of mem_ready / Zero
    Opcode = OPC_BAD;
    step("trap_f", 1'b0, 1'b1, 1'b0, FETCH,  F_RDY, 2'b00);
    step("trap_d", 1'b0, 1'b1, 1'b0, DECODE, DEC_C, 2'b00);
    for (int i = 0; i < 20; i++)
      step($sformatf("trap%0d", i), 1'b0, 1'($urandom_range(0, 1)), 1'b1, TRAP, TRP_C, 2'b00);
    step("trap_rst", 1'b1, 1'b1, 1'b1, TRAP,  RST_TRP, 2'b00);
    Opcode = OPC_ADDI;
    step("post_rst", 1'b0, 1'b0, 1'b0, FETCH, F_STL,   2'b00);
    chk("post_rst_cnt", 32'(retired_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
